// File: rtl/sumsub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT
// cycles, with signed overflow detection and optional saturation of the result.
module sumsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             ov
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one digit added per clock, N clocks
    // S_DONE | result just written, single-cycle done pulse, start accepted
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic               r_sa;
    logic               r_sb;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_f;
    logic               r_ov;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_op;
    logic [DIGIT:0]     w_dsum;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_sat_val;
    logic [WIDTH-1:0]   w_f_nxt;
    logic               w_ov;

    assign w_accept = (r_state != S_RUN) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(N - 1));
    assign w_b_op   = b ^ {WIDTH{op}};

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};

    // The A register doubles as the result register: digits consumed from the
    // bottom free space at the top, where each sum digit is shifted in.
    generate
        if (N == 1) begin : g_single
            assign w_a_nxt = w_dsum[DIGIT-1:0];
        end else begin : g_multi
            assign w_a_nxt = {w_dsum[DIGIT-1:0], r_a[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_ov      = (r_sa == r_sb) && (w_a_nxt[WIDTH-1] != r_sa);
    assign w_sat_val = r_sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_f_nxt   = ((SAT != 0) && w_ov) ? w_sat_val : w_a_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_cnt <= '0;
            r_f   <= '0;
            r_ov  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= w_b_op;
            r_c   <= op;
            r_sa  <= a[WIDTH-1];
            r_sb  <= w_b_op[WIDTH-1];
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= w_a_nxt;
            r_b   <= r_b >> DIGIT;
            r_c   <= w_dsum[DIGIT];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_f  <= w_f_nxt;
                r_ov <= w_ov;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign f    = r_f;
    assign ov   = r_ov;

endmodule

// File: tb/tb_sumsub_serial.sv
// Bench for sumsub_serial: four instances (16/4 wrap, 16/4 saturating, 8/1, 32/8) share
// one stimulus bus; results are checked against an integer-arithmetic reference.
module tb_sumsub_serial;

    localparam int NP   = 20;
    localparam int SEED = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_bus;
    logic [31:0] b_bus;

    logic        busy16, done16, ov16;
    logic [15:0] f16;
    logic        busy16s, done16s, ov16s;
    logic [15:0] f16s;
    logic        busy8, done8, ov8;
    logic [7:0]  f8;
    logic        busy32, done32, ov32;
    logic [31:0] f32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sumsub_serial #(.WIDTH(16), .DIGIT(4), .SAT(0)) dut16 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a_bus[15:0]), .b(b_bus[15:0]),
        .busy(busy16), .done(done16), .f(f16), .ov(ov16)
    );

    sumsub_serial #(.WIDTH(16), .DIGIT(4), .SAT(1)) dut16s (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a_bus[15:0]), .b(b_bus[15:0]),
        .busy(busy16s), .done(done16s), .f(f16s), .ov(ov16s)
    );

    sumsub_serial #(.WIDTH(8), .DIGIT(1), .SAT(0)) dut8 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a_bus[7:0]), .b(b_bus[7:0]),
        .busy(busy8), .done(done8), .f(f8), .ov(ov8)
    );

    sumsub_serial #(.WIDTH(32), .DIGIT(8), .SAT(0)) dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a_bus), .b(b_bus),
        .busy(busy32), .done(done32), .f(f32), .ov(ov32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] f;
        logic        ov;
        logic [15:0] fs;
        logic        ovs;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed integer a+b or a-b, then range check, saturate or wrap.
    function automatic void model(input int w, input bit sat, input logic [31:0] av,
                                  input logic [31:0] bv, input logic opv,
                                  output logic [31:0] ef, output logic eo);
        longint m, sa, sb, r, mx, mn;
        m  = (longint'(1) <<< w) - 1;
        mx = m >>> 1;
        mn = -mx - 1;
        sa = longint'({32'h0, av}) & m;
        sb = longint'({32'h0, bv}) & m;
        if (sa > mx) sa = sa - (m + 1);
        if (sb > mx) sb = sb - (m + 1);
        r  = opv ? (sa - sb) : (sa + sb);
        eo = (r > mx) || (r < mn);
        if (sat && eo) r = (r > mx) ? mx : mn;
        ef = 32'(r & m);
    endfunction

    task automatic start_pulse(input logic [31:0] av, input logic [31:0] bv, input logic opv);
        @(negedge clk);
        a_bus = av;
        b_bus = bv;
        op    = opv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_bus = $urandom;
        b_bus = $urandom;
        op    = ~opv;
    endtask

    task automatic wait_idle(output int nb16, output int nd16, output int nb8, output int nd8,
                             output int nb32, output bit held, output bit tmo);
        logic [15:0] prev;
        nb16 = 0; nd16 = 0; nb8 = 0; nd8 = 0; nb32 = 0;
        held = 1'b1;
        tmo  = 1'b1;
        prev = f16;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy16) begin
                nb16++;
                if (f16 !== prev) held = 1'b0;
            end
            if (done16) nd16++;
            if (busy8)  nb8++;
            if (done8)  nd8++;
            if (busy32) nb32++;
            if (!(busy16 || busy16s || busy8 || busy32 || done16 || done16s || done8 || done32)) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_models(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                input logic opv);
        logic [31:0] ef;
        logic        eo;
        model(16, 1'b0, av, bv, opv, ef, eo);
        check({tag, " f16"}, {16'h0, f16}, ef);
        check({tag, " ov16"}, {31'h0, ov16}, {31'h0, eo});
        model(16, 1'b1, av, bv, opv, ef, eo);
        check({tag, " f16sat"}, {16'h0, f16s}, ef);
        check({tag, " ov16sat"}, {31'h0, ov16s}, {31'h0, eo});
        model(8, 1'b0, av, bv, opv, ef, eo);
        check({tag, " f8"}, {24'h0, f8}, ef);
        check({tag, " ov8"}, {31'h0, ov8}, {31'h0, eo});
        model(32, 1'b0, av, bv, opv, ef, eo);
        check({tag, " f32"}, f32, ef);
        check({tag, " ov32"}, {31'h0, ov32}, {31'h0, eo});
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic opv);
        int nb16, nd16, nb8, nd8, nb32;
        bit held, tmo;
        start_pulse(av, bv, opv);
        wait_idle(nb16, nd16, nb8, nd8, nb32, held, tmo);
        check({tag, " timeout"}, {31'h0, tmo}, 32'h0);
        check({tag, " busy16 cycles"}, nb16, 4);
        check({tag, " done16 pulses"}, nd16, 1);
        check({tag, " busy8 cycles"}, nb8, 8);
        check({tag, " done8 pulses"}, nd8, 1);
        check({tag, " busy32 cycles"}, nb32, 4);
        check({tag, " f16 held in RUN"}, {31'h0, held}, 32'h1);
        check_models(tag, av, bv, opv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ef1, ef2, efs2;
        logic        eo1, eo2, eos2;
        logic [31:0] ra, rb;
        logic        rop;
        int          n, b2b_busy, b2b_done;
        bit          found, held, seen;
        int          nb16, nd16, nb8, nd8, nb32;
        bit          wheld, tmo;

        void'($urandom(SEED));
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_bus = '0;
        b_bus = '0;

        tbl[0] = '{16'd100,  16'd27,   1'b0, 16'd127,  1'b0, 16'd127,  1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
        tbl[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
        tbl[3] = '{16'd5,    16'h8000, 1'b1, 16'h8005, 1'b1, 16'h7FFF, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b1};
        tbl[7] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
        tbl[8] = '{16'd1000, 16'd3000, 1'b1, 16'hF830, 1'b0, 16'hF830, 1'b0};
        tbl[9] = '{16'h7FFF, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1};

        repeat (2) @(negedge clk);
        check("reset busy", {31'h0, busy16}, 32'h0);
        check("reset done", {31'h0, done16}, 32'h0);
        check("reset f", {16'h0, f16}, 32'h0);
        check("reset ov", {31'h0, ov16}, 32'h0);
        reset = 1'b0;

        // Directed 16-bit vectors; upper bus bits are random to exercise the 8/32 instances too.
        for (int i = 0; i < 10; i++) begin
            ra = ($urandom & 32'hFFFF0000) | {16'h0, tbl[i].a};
            rb = ($urandom & 32'hFFFF0000) | {16'h0, tbl[i].b};
            run_op($sformatf("vec%0d", i), ra, rb, tbl[i].op);
            check($sformatf("vec%0d table f", i), {16'h0, f16}, {16'h0, tbl[i].f});
            check($sformatf("vec%0d table ov", i), {31'h0, ov16}, {31'h0, tbl[i].ov});
            check($sformatf("vec%0d table fsat", i), {16'h0, f16s}, {16'h0, tbl[i].fs});
            check($sformatf("vec%0d table ovsat", i), {31'h0, ov16s}, {31'h0, tbl[i].ovs});
        end

        // start pulsed again while running: ignored
        start_pulse(32'd100, 32'd200, 1'b0);
        start_pulse(32'd7, 32'd8, 1'b1);
        wait_idle(nb16, nd16, nb8, nd8, nb32, wheld, tmo);
        check("midrun timeout", {31'h0, tmo}, 32'h0);
        check_models("midrun", 32'd100, 32'd200, 1'b0);
        repeat (3) @(negedge clk);
        check("midrun no second op", {31'h0, busy16}, 32'h0);

        // start in the DONE cycle: back-to-back operation
        model(16, 1'b0, 32'h1234, 32'h0111, 1'b0, ef1, eo1);
        model(16, 1'b0, 32'h2000, 32'h0100, 1'b1, ef2, eo2);
        model(16, 1'b1, 32'h2000, 32'h0100, 1'b1, efs2, eos2);
        start_pulse(32'h1234, 32'h0111, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done16) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b first done seen", {31'h0, found}, 32'h1);
        check("b2b first f", {16'h0, f16}, ef1);
        a_bus = 32'h2000;
        b_bus = 32'h0100;
        op    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_bus = $urandom;
        b_bus = $urandom;
        n = 0; held = 1'b1; b2b_busy = 0; b2b_done = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                b2b_busy = busy16 ? 1 : 0;
                b2b_done = done16 ? 1 : 0;
            end
            if (done16) begin
                n = i;
                break;
            end
            if (f16 !== ef1[15:0]) held = 1'b0;
        end
        check("b2b busy after accept", b2b_busy, 1);
        check("b2b done dropped", b2b_done, 0);
        check("b2b done spacing", n, 5);
        check("b2b f held", {31'h0, held}, 32'h1);
        check("b2b second f", {16'h0, f16}, ef2);
        check("b2b second ov", {31'h0, ov16}, {31'h0, eo2});
        check("b2b second fsat", {16'h0, f16s}, efs2);
        wait_idle(nb16, nd16, nb8, nd8, nb32, wheld, tmo);
        check("b2b settle timeout", {31'h0, tmo}, 32'h0);

        // asynchronous reset in the middle of RUN
        start_pulse(32'h0000_4321, 32'h0000_1111, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset f16", {16'h0, f16}, 32'h0);
        check("async reset ov16", {31'h0, ov16}, 32'h0);
        check("async reset busy16", {31'h0, busy16}, 32'h0);
        check("async reset done16", {31'h0, done16}, 32'h0);
        check("async reset f32", f32, 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done16 || busy16 || done32 || busy8) seen = 1'b1;
        end
        check("no activity in reset", {31'h0, seen}, 32'h0);
        reset = 1'b0;
        run_op("post-reset", 32'h0000_0100, 32'h0000_0200, 1'b0);

        for (int i = 0; i < NP; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ra, rb, rop);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
